// File: rtl/aes_mixcolumns_iter_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative MixColumns engine.
package aes_mixcolumns_iter_pkg;

  localparam int AES_NB      = 4;
  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using shift-and-add over the xtime chain.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x1;
    logic [7:0] x2;
    logic [7:0] x3;
    x1 = xtime(a);
    x2 = xtime(x1);
    x3 = xtime(x2);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x1 : 8'h00) ^
           (k[2] ? x2 : 8'h00) ^ (k[3] ? x3 : 8'h00);
  endfunction

  // Column 0 occupies the MSBs of the state.
  function automatic logic [AES_COL_W-1:0] get_col(input logic [AES_STATE_W-1:0] s,
                                                   input logic [1:0] idx);
    case (idx)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      2'd3:    return s[31:0];
      default: return s[127:96];
    endcase
  endfunction

  function automatic logic [AES_STATE_W-1:0] set_col(input logic [AES_STATE_W-1:0] s,
                                                     input logic [1:0] idx,
                                                     input logic [AES_COL_W-1:0] c);
    logic [AES_STATE_W-1:0] r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      2'd3:    r[31:0]   = c;
      default: r[127:96] = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_mixcolumns_iter_if.sv
// Handshake bus of the MixColumns engine: input side, output side and status.
interface aes_mixcolumns_iter_if;
  import aes_mixcolumns_iter_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   enc;
  logic                   bypass;
  logic [AES_STATE_W-1:0] state_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] state_out;
  logic                   busy;

  modport master (
    output in_valid, enc, bypass, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, enc, bypass, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/aes_mixcolumns_iter_mixcol.sv
// Combinational 32-bit AES column mixer: MixColumns when enc=1, InvMixColumns when enc=0.
module aes_mixcolumns
  import aes_mixcolumns_iter_pkg::*;
(
  input  logic                 enc,
  input  logic [AES_COL_W-1:0] vector_in,
  output logic [AES_COL_W-1:0] vector_out
);

  logic [3:0] coef [4];
  logic [7:0] a    [4];
  logic [7:0] acc  [4];

  // Row i uses the circulant coefficient row rotated by i.
  always_comb begin
    coef[0] = enc ? 4'h2 : 4'hE;
    coef[1] = enc ? 4'h3 : 4'hB;
    coef[2] = enc ? 4'h1 : 4'hD;
    coef[3] = enc ? 4'h1 : 4'h9;
    for (int j = 0; j < 4; j++) begin
      a[j] = vector_in[31-8*j -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      acc[i] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc[i] = acc[i] ^ gf_mul(a[j], coef[2'(j - i)]);
      end
    end
    vector_out = {acc[0], acc[1], acc[2], acc[3]};
  end

endmodule

// File: rtl/aes_mixcolumns_iter.sv
// Iterative MixColumns/InvMixColumns engine for the 128-bit AES state, COLS columns per cycle,
// with valid/ready handshake and a pass-through mode for the final round.
module aes_mixcolumns_iter
  import aes_mixcolumns_iter_pkg::*;
#(
  parameter int COLS    = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_mixcolumns_iter_if.slave  bus
);

  if (!(COLS == 1 || COLS == 2 || COLS == 4)) begin : g_bad_cols
    $error("aes_mixcolumns_iter: COLS must be 1, 2 or 4");
  end

  // STEP is 0 for COLS=4: the 2-bit counter wraps back to 0 after the single group.
  localparam logic [1:0] STEP = 2'(COLS);
  localparam logic [1:0] LAST = 2'(AES_NB - COLS);

  state_e                 state_q;
  logic [AES_STATE_W-1:0] work_q;
  logic [AES_STATE_W-1:0] work_d;
  logic [AES_STATE_W-1:0] state_out_q;
  logic [1:0]             col_cnt_q;
  logic                   enc_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [AES_COL_W-1:0]   mix_in  [COLS];
  logic [AES_COL_W-1:0]   mix_out [COLS];

  for (genvar g = 0; g < COLS; g++) begin : g_mix
    aes_mixcolumns u_mix (
      .enc        (enc_q),
      .vector_in  (mix_in[g]),
      .vector_out (mix_out[g])
    );
  end

  // Select the columns of the current group from the working state.
  always_comb begin
    for (int g = 0; g < COLS; g++) begin
      mix_in[g] = get_col(work_q, col_cnt_q + 2'(g));
    end
  end

  // Write the mixed columns back into their slots.
  always_comb begin
    work_d = work_q;
    for (int g = 0; g < COLS; g++) begin
      work_d = set_col(work_d, col_cnt_q + 2'(g), mix_out[g]);
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      state_out_q <= '0;
      col_cnt_q   <= 2'd0;
      enc_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            work_q     <= bus.state_in;
            enc_q      <= bus.enc;
            col_cnt_q  <= 2'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= bus.bypass ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          work_q    <= work_d;
          col_cnt_q <= col_cnt_q + STEP;
          if (col_cnt_q == LAST) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle captures the result; afterwards hold until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            state_out_q <= work_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.state_out = OUT_REG ? state_out_q : work_q;

endmodule
